dht_sensor_ctrl: RTL and testbench
==================================

# dht_sensor_ctrl

Parametrised single-wire controller for DHT11/DHT22 humidity/temperature sensors. It generates the host start pulse, decodes the 40-bit sensor frame by µs pulse-width measurement, verifies the full 8-bit checksum and publishes raw readings with valid/error strobes. It supports runtime sensor-type selection, auto-polling or on-demand triggering, per-phase timeouts and an enforced inter-read hold-off. It sits between the board pad (external open-drain buffer) and the display/telemetry logic.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency; must be an integer multiple of 1 MHz.
- AUTO_POLL, 1, 1 = self-trigger every POLL_MS; 0 = trigger via start only.
- POLL_MS, 2000, auto-poll period, measured start-to-start.
- HOLDOFF_MS, 1000, minimum gap from end of one transaction to the next start pulse.
- TIMEOUT_US, 255, maximum wait for any expected edge.
- BIT1_US, 48, high-time threshold; high time ≥ BIT1_US decodes as 1.

Ports:
- Reset rst, asynchronous, active-high; clock clk.
- sensor_type, in, 1: 0 = DHT11 (18000 µs start low), 1 = DHT22 (1000 µs start low); sampled on leaving IDLE.
- start, in, 1: single-cycle request.
- data_in, in, 1: raw pad level, asynchronous.
- data_oe, out, 1: 1 = pad driven low; 0 = released (pull-up).
- busy, out, 1: high from leaving IDLE until DONE/ERR completes.
- valid, out, 1: one-cycle strobe when a good frame is published.
- err, out, 1: one-cycle strobe on a failed transaction.
- err_code, out, 2: 0 none, 1 no response, 2 bit timeout, 3 checksum; holds until next err.
- hum_raw, out, 16: {byte0, byte1}.
- temp_raw, out, 16: {byte2, byte3}; DHT22 sign in bit 15.

## Operation
- Input path: 2-flop synchroniser on data_in, then edge detect (rise/fall pulses).
- Tick generator: 1 µs tick every CLK_HZ/1e6 clocks; µs counter is cleared on every state entry.
- FSM states and transitions:
  - IDLE: if trigger pending and holdoff expired -> START_LOW.
  - START_LOW: data_oe=1 for 18000/1000 µs -> RELEASE.
  - RELEASE: data_oe=0; fall -> RESP_LOW.
  - RESP_LOW: rise -> RESP_HIGH.
  - RESP_HIGH: fall -> BIT_LOW.
  - BIT_LOW: rise -> BIT_HIGH.
  - BIT_HIGH: on fall, shift in (µs ≥ BIT1_US), bit_cnt+1; bit_cnt==40 -> CHECK, else -> BIT_LOW.
  - CHECK: (b0+b1+b2+b3) mod 256 == b4 -> DONE, else -> ERR(3).
  - DONE/ERR: one cycle -> IDLE; holdoff timer restarts.
- Timeouts: µs counter > TIMEOUT_US in RELEASE/RESP_LOW/RESP_HIGH -> ERR(1); in BIT_LOW/BIT_HIGH -> ERR(2).
- Triggers: start or the poll timer sets a single pending flag; requests while busy or while a trigger is already pending are merged, not queued. The flag clears on entering START_LOW.
- hum_raw/temp_raw update only in DONE; failures leave the previous values.
- data_oe is high only in START_LOW; there is no active-high drive, ever.

## Timing
- Reset values: data_oe=0, busy=0, valid=0, err=0, err_code=0, hum_raw=0, temp_raw=0, holdoff expired, pending=AUTO_POLL.
- Edge-detect latency: 3 clk from pad to FSM.
- valid/err assert the clk after CHECK (or the timeout detection) and last exactly 1 clk; they are never both high.
- Width accuracy: ±1 µs; the checksum sum is 8-bit with carry discarded.
- rst mid-transaction: data_oe drops to 0 immediately (asynchronously), and the partial frame is discarded.

## Structure
- Package dht_pkg: state_t enum, err_code_t enum (NONE, NO_RESP, BIT_TO, CSUM), sensor_t enum, and the start-low constants 18000/1000.
- Sub-module dht_us_tick: prescaler producing the 1 µs tick (param CLK_HZ). The FSM, shifter and timers stay in the top module.

## Test plan
- DHT11 model sends 35 00 18 00 4D -> valid pulse, hum_raw=0x3500, temp_raw=0x1800, err_code=0; data_oe is low for 18000 µs ±1.
- DHT22 (sensor_type=1) sends 02 8C 80 65 73 -> start low 1000 µs, temp_raw=0x8065, hum_raw=0x028C, valid.
- Checksum byte 0x4E instead of 0x4D -> err pulse, err_code=3, hum_raw/temp_raw keep their prior values, no valid.
- Line held high after release -> err_code=1 after TIMEOUT_US+1 µs; a bit high stuck for 300 µs -> err_code=2.
- start pulsed twice during holdoff (AUTO_POLL=0) -> exactly one start pulse, issued HOLDOFF_MS after the previous completion.
- rst asserted 5 µs into START_LOW -> data_oe=0 within 0 clk; after release, all outputs are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11/DHT22 single-wire controller.
package dht_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NO_RESP = 2'd1,
    ERR_BIT_TO  = 2'd2,
    ERR_CSUM    = 2'd3
  } err_code_t;

  typedef enum logic {
    SENSOR_DHT11 = 1'b0,
    SENSOR_DHT22 = 1'b1
  } sensor_t;

  localparam int unsigned DHT11_START_US = 18000;
  localparam int unsigned DHT22_START_US = 1000;
  localparam int unsigned FRAME_BITS     = 40;

  // Frame is {b0,b1,b2,b3,b4}; b4 must equal the 8-bit sum of the others.
  function automatic logic csum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Free-running prescaler emitting a one-clock pulse every microsecond.
module dht_us_tick #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned DIV = CLK_HZ / 1_000_000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/dht_sensor_ctrl.sv
// DHT11/DHT22 controller: start pulse, pulse-width frame decode, checksum,
// hold-off and polling. The pad is open-drain: data_oe only ever pulls low.
module dht_sensor_ctrl
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned AUTO_POLL  = 1,
  parameter int unsigned POLL_MS    = 2000,
  parameter int unsigned HOLDOFF_MS = 1000,
  parameter int unsigned TIMEOUT_US = 255,
  parameter int unsigned BIT1_US    = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor_type,
  input  logic        start,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] hum_raw,
  output logic [15:0] temp_raw
);

  localparam int unsigned US_W    = 16;
  localparam int unsigned HOLD_US = HOLDOFF_MS * 1000;
  localparam int unsigned HOLD_W  = (HOLD_US > 1) ? $clog2(HOLD_US + 1) : 1;
  localparam int unsigned POLL_US = POLL_MS * 1000;
  localparam int unsigned POLL_W  = (POLL_US > 1) ? $clog2(POLL_US) : 1;

  state_t          r_state;
  logic            r_sync1, r_sync2, r_prev;
  logic            w_rise, w_fall, w_tick, w_go, w_hold_done, w_poll_hit;
  logic            w_timeout, w_bit;
  logic [HOLD_W-1:0] r_hold;
  logic [POLL_W-1:0] r_poll;
  logic [US_W-1:0] r_us, r_start_low;
  logic [39:0]     r_shift;
  logic [5:0]      r_bit_cnt;
  logic            r_pending, r_data_oe, r_busy, r_valid, r_err;
  err_code_t       r_err_code;
  logic [15:0]     r_hum, r_temp;

  // Pad synchroniser; idles high to match the pull-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;

  dht_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // Hold-off restarts when a transaction finishes; expired out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == S_DONE || r_state == S_ERR) begin
      r_hold <= HOLD_W'(HOLD_US);
    end else if (w_tick && r_hold != '0) begin
      r_hold <= r_hold - HOLD_W'(1);
    end
  end

  assign w_hold_done = (r_hold == '0);
  assign w_go        = (r_state == S_IDLE) && r_pending && w_hold_done;

  // Poll period is measured start-to-start, so it restarts with each start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poll <= '0;
    end else if (w_go) begin
      r_poll <= '0;
    end else if (w_tick) begin
      r_poll <= (r_poll == POLL_W'(POLL_US - 1)) ? '0 : r_poll + POLL_W'(1);
    end
  end

  assign w_poll_hit = (AUTO_POLL != 0) && w_tick && (r_poll == POLL_W'(POLL_US - 1));
  assign w_timeout  = (r_us > US_W'(TIMEOUT_US));
  assign w_bit      = (r_us >= US_W'(BIT1_US));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pending   <= (AUTO_POLL != 0);
      r_us        <= '0;
      r_start_low <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_data_oe   <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_hum       <= '0;
      r_temp      <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (start || w_poll_hit) r_pending <= 1'b1;
      if (w_tick && (r_us != '1)) r_us <= r_us + US_W'(1);
      case (r_state)
        S_IDLE: if (w_go) begin
          r_state     <= S_START_LOW;
          r_pending   <= 1'b0;
          r_us        <= '0;
          r_data_oe   <= 1'b1;
          r_busy      <= 1'b1;
          r_start_low <= (sensor_t'(sensor_type) == SENSOR_DHT22) ?
                         US_W'(DHT22_START_US) : US_W'(DHT11_START_US);
          r_shift     <= '0;
          r_bit_cnt   <= '0;
        end
        S_START_LOW: if (r_us >= r_start_low) begin
          r_state   <= S_RELEASE;
          r_us      <= '0;
          r_data_oe <= 1'b0;
        end
        S_RELEASE, S_RESP_LOW, S_RESP_HIGH: begin
          if (r_state == S_RELEASE && w_fall) begin
            r_state <= S_RESP_LOW;
            r_us    <= '0;
          end else if (r_state == S_RESP_LOW && w_rise) begin
            r_state <= S_RESP_HIGH;
            r_us    <= '0;
          end else if (r_state == S_RESP_HIGH && w_fall) begin
            r_state <= S_BIT_LOW;
            r_us    <= '0;
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_us       <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_NO_RESP;
          end
        end
        S_BIT_LOW: begin
          if (w_rise) begin
            r_state <= S_BIT_HIGH;
            r_us    <= '0;
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_us       <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_BIT_TO;
          end
        end
        // High time at the falling edge decides the bit value.
        S_BIT_HIGH: begin
          if (w_fall) begin
            r_shift   <= {r_shift[38:0], w_bit};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_us      <= '0;
            r_state   <= (r_bit_cnt == 6'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_us       <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_BIT_TO;
          end
        end
        S_CHECK: begin
          r_us <= '0;
          if (csum_ok(r_shift)) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_hum   <= r_shift[39:24];
            r_temp  <= r_shift[23:8];
          end else begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_CSUM;
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_us    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_oe  = r_data_oe;
  assign busy     = r_busy;
  assign valid    = r_valid;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign hum_raw  = r_hum;
  assign temp_raw = r_temp;

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// Bench for dht_sensor_ctrl: scripted open-drain sensor plus a frame-level
// reference model checked every cycle, pinned by literal readings.
`timescale 1ns/1ps
module tb_dht_sensor_ctrl;

  localparam int CLK_HZ     = 2_000_000;
  localparam int CPU        = CLK_HZ / 1_000_000;
  localparam int HOLDOFF_MS = 1;
  localparam int HOLD_US    = HOLDOFF_MS * 1000;
  localparam int TIMEOUT_US = 255;
  localparam int BIT1_US    = 48;
  localparam int MODE_OK     = 0;
  localparam int MODE_NORESP = 1;
  localparam int MODE_STUCK  = 2;

  logic        clk = 1'b0;
  logic        rst, sensor_type, start, data_in, s_low;
  logic        data_oe, busy, valid, err;
  logic [1:0]  err_code;
  logic [15:0] hum_raw, temp_raw;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model state: published readings, last error code, pending expectation.
  logic [15:0] m_hum = '0, m_temp = '0, p_hum = '0, p_temp = '0;
  int          m_code = 0, p_code = 0, m_exp = 0;
  int          n_strobe = 0, t_strobe = 0;
  int          oe_rises = 0, oe_falls = 0, t_oe_rise = 0, t_oe_fall = 0;
  logic        oe_d = 1'b0;

  assign data_in = ~(data_oe | s_low);

  always #250 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dht_sensor_ctrl #(
    .CLK_HZ(CLK_HZ), .AUTO_POLL(0), .POLL_MS(2000), .HOLDOFF_MS(HOLDOFF_MS),
    .TIMEOUT_US(TIMEOUT_US), .BIT1_US(BIT1_US)
  ) dut (
    .clk(clk), .rst(rst), .sensor_type(sensor_type), .start(start),
    .data_in(data_in), .data_oe(data_oe), .busy(busy), .valid(valid),
    .err(err), .err_code(err_code), .hum_raw(hum_raw), .temp_raw(temp_raw)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Predicts the outcome of one transaction from the frame and scenario.
  task automatic set_expect(input logic [39:0] f, input int mode);
    int sum;
    sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    if (mode == MODE_NORESP) begin
      m_exp = 2; p_code = 1;
    end else if (mode == MODE_STUCK) begin
      m_exp = 2; p_code = 2;
    end else if (sum == int'(f[7:0])) begin
      m_exp = 1; p_hum = f[39:24]; p_temp = f[23:8];
    end else begin
      m_exp = 2; p_code = 3;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_hum = '0; m_temp = '0; m_code = 0; m_exp = 0; oe_d = 1'b0;
    end else begin
      if (data_oe && !oe_d) begin oe_rises++; t_oe_rise = cyc; end
      if (!data_oe && oe_d) begin oe_falls++; t_oe_fall = cyc; end
      oe_d = data_oe;
      check("valid_err_excl", int'(valid & err), 0);
      if (valid) begin
        check("valid_expected", m_exp, 1);
        check("hum_publish", int'(hum_raw), int'(p_hum));
        check("temp_publish", int'(temp_raw), int'(p_temp));
        check("code_on_valid", int'(err_code), m_code);
        m_hum = p_hum; m_temp = p_temp; m_exp = 0;
        n_strobe++; t_strobe = cyc;
      end else if (err) begin
        check("err_expected", m_exp, 2);
        check("err_code", int'(err_code), p_code);
        check("hum_keep_on_err", int'(hum_raw), int'(m_hum));
        check("temp_keep_on_err", int'(temp_raw), int'(m_temp));
        m_code = p_code; m_exp = 0;
        n_strobe++; t_strobe = cyc;
      end else begin
        check("hum_hold", int'(hum_raw), int'(m_hum));
        check("temp_hold", int'(temp_raw), int'(m_temp));
        check("code_hold", int'(err_code), m_code);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic sens_drive(input logic low, input int us);
    #1 s_low = low;
    repeat (us * CPU) @(posedge clk);
  endtask

  task automatic wait_rise(input int r0, input int bound, input string name);
    int k = 0;
    while (oe_rises == r0 && k < bound) begin @(posedge clk); k++; end
    check(name, int'(oe_rises != r0), 1);
  endtask

  task automatic wait_fall(input int f0, input int bound, input string name);
    int k = 0;
    while (oe_falls == f0 && k < bound) begin @(posedge clk); k++; end
    check(name, int'(oe_falls != f0), 1);
  endtask

  task automatic wait_strobe(input int n0, input int bound, input string name);
    int k = 0;
    while (n_strobe == n0 && k < bound) begin @(posedge clk); k++; end
    check(name, int'(n_strobe != n0), 1);
  endtask

  // Sensor side: observe the start pulse, then answer with the frame.
  task automatic sensor_txn(input logic [39:0] f, input int mode, input int low_us, input int r0);
    int f0;
    f0 = oe_falls;
    wait_rise(r0, (HOLD_US + 50) * CPU, "oe_rise_seen");
    @(negedge clk);
    check("busy_in_start", int'(busy), 1);
    wait_fall(f0, (low_us + 10) * CPU, "oe_fall_seen");
    check_rng("start_low_cycles", t_oe_fall - t_oe_rise, (low_us - 1) * CPU, (low_us + 1) * CPU);
    if (mode == MODE_NORESP) return;
    sens_drive(1'b0, 20);
    sens_drive(1'b1, 80);
    sens_drive(1'b0, 80);
    for (int i = 0; i < 40; i++) begin
      sens_drive(1'b1, 20);
      if (mode == MODE_STUCK && i == 8) begin
        sens_drive(1'b0, 300);
        return;
      end
      sens_drive(1'b0, f[39 - i] ? 60 : 20);
    end
    sens_drive(1'b1, 20);
    #1 s_low = 1'b0;
  endtask

  initial begin
    #80_000_000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, n0, t_req, t_done;
    rst = 1'b1; start = 1'b0; sensor_type = 1'b0; s_low = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data_oe", int'(data_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_hum", int'(hum_raw), 0);
    check("rst_temp", int'(temp_raw), 0);

    // DHT11 good frame; hold-off is expired out of reset.
    sensor_type = 1'b0;
    set_expect(40'h35_00_18_00_4D, MODE_OK);
    r0 = oe_rises; n0 = n_strobe; t_req = cyc;
    pulse_start();
    sensor_txn(40'h35_00_18_00_4D, MODE_OK, 18000, r0);
    check_rng("first_start_latency", t_oe_rise - t_req, 0, 8);
    wait_strobe(n0, 100 * CPU, "dht11_strobe");
    @(negedge clk);
    check("dht11_hum", int'(hum_raw), 'h3500);
    check("dht11_temp", int'(temp_raw), 'h1800);
    check("dht11_code", int'(err_code), 0);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);

    // DHT22 good frame; two starts during hold-off merge into one.
    t_done = t_strobe;
    sensor_type = 1'b1;
    set_expect(40'h02_8C_80_65_73, MODE_OK);
    r0 = oe_rises; n0 = n_strobe;
    repeat (100 * CPU) @(posedge clk);
    pulse_start();
    repeat (200 * CPU) @(posedge clk);
    pulse_start();
    sensor_txn(40'h02_8C_80_65_73, MODE_OK, 1000, r0);
    check_rng("holdoff_gap", t_oe_rise - t_done, HOLD_US * CPU - 2, HOLD_US * CPU + 6);
    wait_strobe(n0, 100 * CPU, "dht22_strobe");
    @(negedge clk);
    check("dht22_hum", int'(hum_raw), 'h028C);
    check("dht22_temp", int'(temp_raw), 'h8065);
    repeat ((HOLD_US + 200) * CPU) @(posedge clk);
    check("single_start", oe_rises - r0, 1);

    // Bad checksum keeps previous readings.
    set_expect(40'h35_00_18_00_4E, MODE_OK);
    r0 = oe_rises; n0 = n_strobe;
    pulse_start();
    sensor_txn(40'h35_00_18_00_4E, MODE_OK, 1000, r0);
    wait_strobe(n0, 100 * CPU, "csum_strobe");
    @(negedge clk);
    check("csum_code", int'(err_code), 3);
    check("csum_hum_kept", int'(hum_raw), 'h028C);
    check("csum_temp_kept", int'(temp_raw), 'h8065);

    // No response after release.
    set_expect(40'h0, MODE_NORESP);
    r0 = oe_rises; n0 = n_strobe;
    pulse_start();
    sensor_txn(40'h0, MODE_NORESP, 1000, r0);
    wait_strobe(n0, (TIMEOUT_US + 50) * CPU, "noresp_strobe");
    check_rng("noresp_latency", t_strobe - t_oe_fall, (TIMEOUT_US + 1) * CPU - 2, (TIMEOUT_US + 1) * CPU + 3);
    @(negedge clk);
    check("noresp_code", int'(err_code), 1);

    // Bit high stuck for 300 us.
    set_expect(40'h02_8C_80_65_73, MODE_STUCK);
    r0 = oe_rises; n0 = n_strobe;
    pulse_start();
    sensor_txn(40'h02_8C_80_65_73, MODE_STUCK, 1000, r0);
    wait_strobe(n0, (TIMEOUT_US + 50) * CPU, "stuck_strobe");
    @(negedge clk);
    check("stuck_code", int'(err_code), 2);
    check("stuck_hum_kept", int'(hum_raw), 'h028C);

    // Reset 5 us into the start pulse.
    r0 = oe_rises;
    pulse_start();
    wait_rise(r0, (HOLD_US + 50) * CPU, "rst_txn_rise");
    repeat (5 * CPU) @(posedge clk);
    #10 rst = 1'b1;
    #1 check("rst_async_oe", int'(data_oe), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_data_oe", int'(data_oe), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_valid", int'(valid), 0);
    check("rst2_err", int'(err), 0);
    check("rst2_err_code", int'(err_code), 0);
    check("rst2_hum", int'(hum_raw), 0);
    check("rst2_temp", int'(temp_raw), 0);
    repeat (300 * CPU) @(posedge clk);
    check("no_restart_after_rst", oe_rises - r0, 1);

    // Hold-off is expired after reset, so a new start goes out at once.
    set_expect(40'h0, MODE_NORESP);
    r0 = oe_rises; n0 = n_strobe; t_req = cyc;
    pulse_start();
    sensor_txn(40'h0, MODE_NORESP, 1000, r0);
    check_rng("post_rst_start_latency", t_oe_rise - t_req, 0, 8);
    wait_strobe(n0, (TIMEOUT_US + 50) * CPU, "post_rst_strobe");
    @(negedge clk);
    check("post_rst_code", int'(err_code), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
